// File: rtl/uart_pkg.sv
// Types, limits and the parity helper shared by the UART receive and transmit engines.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  localparam int unsigned MIN_BYTE_SIZE    = 5;
  localparam int unsigned MAX_BYTE_SIZE    = 9;
  localparam int unsigned MIN_CLK_PER_BAUD = 4;

  // Even parity over the low 'size' bits of data.
  function automatic logic even_parity(input logic [8:0] data, input logic [3:0] size);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < int'(size)) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Two-flop rxd synchroniser plus majority voter over the sample window ending at the bit mid-point.
module uart_bit_sampler #(
  parameter int MULTI_SAMPLE_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic                          win_active,
  input  logic                          mid_strobe,
  input  logic [MULTI_SAMPLE_WIDTH-1:0] m_eff,
  output logic                          rs,
  output logic                          bit_vote,
  output logic                          vote_valid
);

  localparam int VW = MULTI_SAMPLE_WIDTH + 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [VW-1:0] ones_q, ones_d;
  logic [VW-1:0] ones_total;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      ones_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    sync1_d    = rxd;
    sync2_d    = sync1_q;
    ones_total = ones_q + {{(VW-1){1'b0}}, sync2_q};
    ones_d     = ones_q;
    if (mid_strobe || !win_active) ones_d = '0;
    else                           ones_d = ones_total;
  end

  assign rs         = sync2_q;
  assign vote_valid = mid_strobe;
  // ones*2 >= M, so a tie votes for the idle level
  assign bit_vote   = ({ones_total, 1'b0} >= {2'b00, m_eff});

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: start-edge detect, voted bit sampling, parity/stop/break checking.
// state      | meaning
// IDLE       | waiting for a falling edge on rs
// START      | confirming the start bit at its mid-point
// DATA       | collecting byte_size data bits, LSB first
// PARITY     | sampling the even-parity bit
// STOP       | sampling one or two stop bits; rx strobes after the last mid-point
// BREAK_WAIT | line held low after a break; waiting for one full idle baud period
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUD_WIDTH         = 16,
  parameter int MULTI_SAMPLE_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic [BAUD_WIDTH-1:0]         clk_per_baud,
  input  logic [3:0]                    byte_size,
  input  logic                          parity,
  input  logic [1:0]                    stop_bits,
  input  logic [MULTI_SAMPLE_WIDTH-1:0] multi_sample,
  output logic [8:0]                    rx_data,
  output logic                          rx,
  output logic                          rx_busy,
  output logic                          err_break,
  output logic                          err_parity,
  output logic                          err_frame
);

  rx_state_t                     state_q, state_d;
  logic [BAUD_WIDTH-1:0]         cnt_q, cnt_d, p_q, p_d;
  logic [3:0]                    size_q, size_d, bit_idx_q, bit_idx_d;
  logic                          par_en_q, par_en_d, two_stop_q, two_stop_d;
  logic [MULTI_SAMPLE_WIDTH-1:0] m_q, m_d;
  logic [8:0]                    shift_q, shift_d, rx_data_q, rx_data_d;
  logic                          any_one_q, any_one_d, par_bit_q, par_bit_d;
  logic                          stop1_q, stop1_d, stop_idx_q, stop_idx_d;
  logic                          rs_prev_q, rs_prev_d, rx_q, rx_d;
  logic                          err_break_q, err_break_d, err_parity_q, err_parity_d;
  logic                          err_frame_q, err_frame_d;

  logic                          rs, bit_vote, vote_valid;
  logic [BAUD_WIDTH-1:0]         mid, p_in;
  logic [BAUD_WIDTH:0]           mid_p1, win_start;
  logic [MULTI_SAMPLE_WIDTH-1:0] m_eff, m_in;
  logic [3:0]                    size_in;
  logic                          sampling, win_active, mid_hit, bit_end;
  logic                          s1, last_stop, brk, frame_bad;

  assign p_in    = (clk_per_baud < BAUD_WIDTH'(MIN_CLK_PER_BAUD)) ?
                   BAUD_WIDTH'(MIN_CLK_PER_BAUD) : clk_per_baud;
  assign size_in = (byte_size < 4'(MIN_BYTE_SIZE)) ? 4'(MIN_BYTE_SIZE) :
                   (byte_size > 4'(MAX_BYTE_SIZE)) ? 4'(MAX_BYTE_SIZE) : byte_size;
  assign m_in    = (multi_sample == '0) ? MULTI_SAMPLE_WIDTH'(1) : multi_sample;

  // Window never reaches back past the bit boundary: at most mid+1 samples.
  assign mid        = p_q >> 1;
  assign mid_p1     = {1'b0, mid} + (BAUD_WIDTH+1)'(1);
  assign m_eff      = ((BAUD_WIDTH+1)'(m_q) > mid_p1) ? MULTI_SAMPLE_WIDTH'(mid_p1) : m_q;
  assign win_start  = mid_p1 - (BAUD_WIDTH+1)'(m_eff);
  assign sampling   = state_q inside {START, DATA, PARITY, STOP};
  assign mid_hit    = sampling && (cnt_q == mid);
  assign win_active = sampling && ({1'b0, cnt_q} >= win_start) && (cnt_q <= mid);
  assign bit_end    = (cnt_q == p_q - BAUD_WIDTH'(1));

  uart_bit_sampler #(
    .MULTI_SAMPLE_WIDTH(MULTI_SAMPLE_WIDTH)
  ) u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .win_active (win_active),
    .mid_strobe (mid_hit),
    .m_eff      (m_eff),
    .rs         (rs),
    .bit_vote   (bit_vote),
    .vote_valid (vote_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      p_q          <= BAUD_WIDTH'(MIN_CLK_PER_BAUD);
      size_q       <= 4'(MIN_BYTE_SIZE);
      bit_idx_q    <= '0;
      par_en_q     <= 1'b0;
      two_stop_q   <= 1'b0;
      m_q          <= MULTI_SAMPLE_WIDTH'(1);
      shift_q      <= '0;
      rx_data_q    <= '0;
      any_one_q    <= 1'b0;
      par_bit_q    <= 1'b0;
      stop1_q      <= 1'b1;
      stop_idx_q   <= 1'b0;
      rs_prev_q    <= 1'b1;
      rx_q         <= 1'b0;
      err_break_q  <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      size_q       <= size_d;
      bit_idx_q    <= bit_idx_d;
      par_en_q     <= par_en_d;
      two_stop_q   <= two_stop_d;
      m_q          <= m_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      any_one_q    <= any_one_d;
      par_bit_q    <= par_bit_d;
      stop1_q      <= stop1_d;
      stop_idx_q   <= stop_idx_d;
      rs_prev_q    <= rs_prev_d;
      rx_q         <= rx_d;
      err_break_q  <= err_break_d;
      err_parity_q <= err_parity_d;
      err_frame_q  <= err_frame_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    p_d          = p_q;
    size_d       = size_q;
    bit_idx_d    = bit_idx_q;
    par_en_d     = par_en_q;
    two_stop_d   = two_stop_q;
    m_d          = m_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    any_one_d    = any_one_q;
    par_bit_d    = par_bit_q;
    stop1_d      = stop1_q;
    stop_idx_d   = stop_idx_q;
    rs_prev_d    = rs;
    rx_d         = 1'b0;
    err_break_d  = err_break_q;
    err_parity_d = err_parity_q;
    err_frame_d  = err_frame_q;
    s1           = stop_idx_q ? stop1_q : bit_vote;
    last_stop    = !two_stop_q || stop_idx_q;
    brk          = !any_one_q && !s1;
    frame_bad    = !s1 || (stop_idx_q && !bit_vote);

    if (sampling) cnt_d = bit_end ? '0 : cnt_q + BAUD_WIDTH'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rs_prev_q && !rs) begin
          state_d    = START;
          p_d        = p_in;
          size_d     = size_in;
          par_en_d   = parity;
          two_stop_d = (stop_bits >= 2'd2);
          m_d        = m_in;
          bit_idx_d  = '0;
          shift_d    = '0;
          any_one_d  = 1'b0;
          par_bit_d  = 1'b0;
          stop1_d    = 1'b1;
          stop_idx_d = 1'b0;
        end
      end
      START: begin
        if (vote_valid && bit_vote) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (vote_valid) begin
          any_one_d = any_one_q | bit_vote;
          if (bit_idx_q < size_q) begin
            shift_d[bit_idx_q] = bit_vote;
            bit_idx_d          = bit_idx_q + 4'd1;
          end
        end
        if (bit_end && (bit_idx_q == size_q)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (vote_valid) begin
          par_bit_d = bit_vote;
          any_one_d = any_one_q | bit_vote;
        end
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (vote_valid) begin
          if (!stop_idx_q) stop1_d = bit_vote;
          if (last_stop) begin
            rx_d         = 1'b1;
            rx_data_d    = shift_q;
            err_break_d  = brk;
            err_frame_d  = frame_bad && !brk;
            err_parity_d = par_en_q && (par_bit_q != even_parity(shift_q, size_q));
            state_d      = brk ? BREAK_WAIT : IDLE;
            cnt_d        = '0;
          end
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      BREAK_WAIT: begin
        if (!rs) begin
          cnt_d = '0;
        end else if (bit_end) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + BAUD_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data    = rx_data_q;
  assign rx         = rx_q;
  assign rx_busy    = (state_q != IDLE);
  assign err_break  = err_break_q;
  assign err_parity = err_parity_q;
  assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomized back-to-back traffic.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] clk_per_baud = 16'd16;
  logic [3:0]  byte_size = 4'd8;
  logic        parity = 1'b0;
  logic [1:0]  stop_bits = 2'd1;
  logic [3:0]  multi_sample = 4'd1;
  logic [8:0]  rx_data;
  logic        rx, rx_busy, err_break, err_parity, err_frame;

  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt = 0;
  int          cyc = 0;
  int          last_strobe_cyc = 0;
  logic [11:0] rx_q[$];

  int p_raw = 16, size_raw = 8, stop_raw = 1, m_raw = 1;
  bit par_en = 1'b0;

  uart_rx_core #(.BAUD_WIDTH(16), .MULTI_SAMPLE_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .clk_per_baud (clk_per_baud),
    .byte_size    (byte_size),
    .parity       (parity),
    .stop_bits    (stop_bits),
    .multi_sample (multi_sample),
    .rx_data      (rx_data),
    .rx           (rx),
    .rx_busy      (rx_busy),
    .err_break    (err_break),
    .err_parity   (err_parity),
    .err_frame    (err_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && rx) begin
      rx_q.push_back({err_break, err_parity, err_frame, rx_data});
      strobe_cnt      = strobe_cnt + 1;
      last_strobe_cyc = cyc;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int eff_size(input int raw);
    return (raw < 5) ? 5 : (raw > 9) ? 9 : raw;
  endfunction

  function automatic int eff_p(input int raw);
    return (raw < 4) ? 4 : raw;
  endfunction

  // Reference: what a receiver should report for a frame put on the wire.
  function automatic logic [11:0] model(input logic [8:0] data, input int sz, input bit pe,
                                        input bit pflip, input bit s1, input bit s2, input bit two);
    logic [8:0] d;
    logic       wire_par, perr, brk, fe;
    d = '0;
    for (int i = 0; i < sz; i++) d[i] = data[i];
    wire_par = (^d) ^ pflip;
    perr     = pe && (wire_par != (^d));
    brk      = (d == 9'd0) && (!pe || !wire_par) && !s1;
    fe       = !brk && (!s1 || (two && !s2));
    return {brk, perr, fe, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int p, input int sz, input bit pe, input int st, input int m);
    p_raw = p; size_raw = sz; par_en = pe; stop_raw = st; m_raw = m;
  endtask

  task automatic drive_bit(input logic val, input int p, input bit glitch);
    for (int c = 0; c < p; c++) begin
      rxd = (glitch && c == p / 2) ? ~val : val;
      tick();
    end
  endtask

  task automatic send_frame(input logic [8:0] data, input bit pflip, input bit s1, input bit s2,
                            input bit glitch, input bit scramble);
    int   p, sz;
    bit   two;
    logic pb;
    p  = eff_p(p_raw);
    sz = eff_size(size_raw);
    two = (stop_raw >= 2);
    clk_per_baud = 16'(p_raw);
    byte_size    = 4'(size_raw);
    parity       = par_en;
    stop_bits    = 2'(stop_raw);
    multi_sample = 4'(m_raw);
    drive_bit(1'b0, p, glitch);
    if (scramble) begin
      clk_per_baud = 16'($urandom);
      byte_size    = 4'($urandom);
      parity       = 1'($urandom);
      stop_bits    = 2'($urandom);
      multi_sample = 4'($urandom);
    end
    pb = pflip;
    for (int i = 0; i < sz; i++) begin
      drive_bit(data[i], p, glitch);
      pb = pb ^ data[i];
    end
    if (par_en) drive_bit(pb, p, glitch);
    drive_bit(s1, p, glitch);
    if (two) drive_bit(s2, p, glitch);
    rxd = 1'b1;
  endtask

  task automatic wait_strobe(input int budget, output bit ok, output logic [11:0] got);
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < budget; i++) begin
      if (rx_q.size() > 0) begin
        got = rx_q.pop_front();
        ok  = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_data !== 9'h000) begin
      errors++; $display("FAIL reset_rx_data: got %h expected 000", rx_data);
    end
    checks++;
    if ({rx, rx_busy, err_break, err_parity, err_frame} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got rx/busy/brk/par/frm=%b expected 00000",
               {rx, rx_busy, err_break, err_parity, err_frame});
    end
    tick();
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL sync_reset_edge: rx_busy got %b expected 1", rx_busy);
    end
    rxd = 1'b1;
    repeat (48) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0 || strobe_cnt != 0) begin
      errors++;
      $display("FAIL reset_glitch_abort: busy %b strobes %0d expected busy 0 strobes 0", rx_busy, strobe_cnt);
    end
    tick();
  endtask

  task automatic test_loopback();
    bit ok; logic [11:0] got, exp; int t0;
    set_cfg(16, 8, 0, 1, 1);
    t0 = cyc;
    send_frame(9'h0A5, 0, 1, 1, 0, 0);
    wait_strobe(64, ok, got);
    exp = model(9'h0A5, 8, 0, 0, 1, 1, 0);
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL loopback_a5: got %h (seen %0d) expected %h", got, ok, exp);
    end
    checks++;
    if (!ok || (last_strobe_cyc - t0) < 145 || (last_strobe_cyc - t0) > 165) begin
      errors++;
      $display("FAIL loopback_latency: strobe %0d cycles after start expected 145..165", last_strobe_cyc - t0);
    end
    drive_bit(1'b1, 16, 0);
  endtask

  task automatic test_9e2_glitch();
    bit ok; logic [11:0] got, exp;
    set_cfg(16, 9, 1, 2, 3);
    send_frame(9'h1FF, 0, 1, 1, 1, 0);
    wait_strobe(64, ok, got);
    exp = model(9'h1FF, 9, 1, 0, 1, 1, 1);
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL glitch_9e2: got %h (seen %0d) expected %h", got, ok, exp);
    end
    drive_bit(1'b1, 16, 0);
  endtask

  task automatic test_parity_err();
    bit ok; logic [11:0] got, exp;
    set_cfg(16, 8, 1, 1, 1);
    send_frame(9'h003, 1, 1, 1, 0, 0);
    wait_strobe(64, ok, got);
    exp = {1'b0, 1'b1, 1'b0, 9'h003};
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL parity_err: got %h (seen %0d) expected %h", got, ok, exp);
    end
    drive_bit(1'b1, 16, 0);
  endtask

  task automatic test_frame_err();
    bit ok; logic [11:0] got, exp;
    set_cfg(16, 8, 0, 0, 1);
    send_frame(9'h055, 0, 0, 1, 0, 0);
    wait_strobe(64, ok, got);
    exp = {1'b0, 1'b0, 1'b1, 9'h055};
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL frame_err: got %h (seen %0d) expected %h", got, ok, exp);
    end
    drive_bit(1'b1, 32, 0);
    send_frame(9'h066, 0, 1, 1, 0, 0);
    wait_strobe(64, ok, got);
    exp = {3'b000, 9'h066};
    checks++;
    if (!ok || got !== exp) begin
      errors++; $display("FAIL frame_recover: got %h (seen %0d) expected %h", got, ok, exp);
    end
    drive_bit(1'b1, 16, 0);
  endtask

  task automatic test_break();
    bit ok; logic [11:0] got; int n0;
    set_cfg(16, 8, 0, 1, 1);
    clk_per_baud = 16'd16; byte_size = 4'd8; parity = 1'b0; stop_bits = 2'd1; multi_sample = 4'd1;
    n0 = strobe_cnt;
    drive_bit(1'b0, 30 * 16, 0);
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL break_busy_low: rx_busy got %b expected 1", rx_busy);
    end
    wait_strobe(4, ok, got);
    checks++;
    if (!ok || got !== {1'b1, 1'b0, 1'b0, 9'h000}) begin
      errors++; $display("FAIL break_flags: got %h (seen %0d) expected 800", got, ok);
    end
    tick();
    rxd = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL break_busy_release: rx_busy got %b expected 1", rx_busy);
    end
    repeat (16) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++; $display("FAIL break_busy_end: rx_busy got %b expected 0", rx_busy);
    end
    drive_bit(1'b1, 48, 0);
    checks++;
    if (strobe_cnt - n0 != 1) begin
      errors++; $display("FAIL break_single_strobe: strobes %0d expected 1", strobe_cnt - n0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [11:0] got; int n0;
    set_cfg(16, 8, 0, 1, 1);
    clk_per_baud = 16'd16; byte_size = 4'd8; parity = 1'b0; stop_bits = 2'd1; multi_sample = 4'd1;
    n0 = strobe_cnt;
    drive_bit(1'b0, 16, 0);
    drive_bit(1'b0, 16, 0);
    drive_bit(1'b0, 16, 0);
    drive_bit(1'b1, 8, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive_bit(1'b1, 200, 0);
    @(negedge clk);
    checks++;
    if (strobe_cnt != n0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: strobes %0d busy %b expected 0 and 0", strobe_cnt - n0, rx_busy);
    end
    tick();
    send_frame(9'h03C, 0, 1, 1, 0, 0);
    wait_strobe(64, ok, got);
    checks++;
    if (!ok || got !== {3'b000, 9'h03C}) begin
      errors++; $display("FAIL reset_mid_next: got %h (seen %0d) expected 03c", got, ok);
    end
    drive_bit(1'b1, 16, 0);
  endtask

  task automatic test_start_glitch();
    int n0;
    clk_per_baud = 16'd16; multi_sample = 4'd1;
    n0 = strobe_cnt;
    drive_bit(1'b0, 3, 0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL glitch_edge_seen: rx_busy got %b expected 1", rx_busy);
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0 || strobe_cnt != n0) begin
      errors++;
      $display("FAIL glitch_reject: busy %b strobes %0d expected 0 and 0", rx_busy, strobe_cnt - n0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok; logic [11:0] got, exp; logic [8:0] d; bit pf;
    for (int n = 0; n < 24; n++) begin
      set_cfg($urandom_range(0, 24), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 15));
      d  = 9'($urandom_range(0, 511));
      pf = par_en && ($urandom_range(0, 3) == 0);
      exp = model(d, eff_size(size_raw), par_en, pf, 1, 1, stop_raw >= 2);
      send_frame(d, pf, 1, 1, 0, 1);
      wait_strobe(16, ok, got);
      checks++;
      if (!ok || got !== exp) begin
        errors++;
        $display("FAIL b2b_%0d: got %h (seen %0d) expected %h p=%0d sz=%0d par=%0d st=%0d m=%0d",
                 n, got, ok, exp, p_raw, size_raw, par_en, stop_raw, m_raw);
      end
    end
    drive_bit(1'b1, 32, 0);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_9e2_glitch();
    test_parity_err();
    test_frame_err();
    test_break();
    test_reset_mid();
    test_start_glitch();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
